mod_down_counter: RTL and testbench

- Synchronous, loadable, modulo-N down counter. It is the counting-down counterpart to the team's 3-bit modulo-6 up counter (counter3).
- Used by the ALU sequencing logic for remaining-cycle and iteration counts.
- Provides a registered count, a zero flag and a one-cycle borrow pulse on wrap.
- All state changes on the rising edge of CLK, except the asynchronous reset.

---
 rtl/mod_down_counter.sv | 85 ++++++++
 tb/tb_mod_down_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mod_down_counter.sv
// ---------------------------------------------------------------------------
// mod_down_counter
//
// Synchronous, loadable, modulo-MOD down counter. It is the counting-down
// partner of counter3 and is used by the ALU sequencer for remaining-cycle
// and iteration counts.
//
// WIDTH sets the count register and DIN/OUT width. The modulus gives a count
// range of 0..MOD-1 and must satisfy 2 <= MOD <= 2**WIDTH.
//
// Ports
//   CLK   in  1      rising-edge clock
//   RST_N in  1      asynchronous active-low reset (OUT=0, BRW=0)
//   CNT   in  1      count enable, decrement by one per edge
//   LOAD  in  1      synchronous load strobe, has priority over CNT
//   DIN   in  WIDTH  load value, values above MOD-1 clamp to MOD-1
//   OUT   out WIDTH  registered count
//   ZERO  out 1      OUT == 0, decoded straight from the register
//   BRW   out 1      registered one-cycle pulse after a wrap at zero
//
// The saturating build holds the count at 0 instead of wrapping to MOD-1
// when counting at zero; BRW still pulses to flag the underflow attempt.
// ---------------------------------------------------------------------------
module mod_down_counter #(
    parameter int WIDTH = 3,
    parameter int MOD   = 6
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CNT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] OUT,
    output logic             ZERO,
    output logic             BRW
);

    // Reject illegal moduli at elaboration time.
    generate
        if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
            $error("mod_down_counter: MOD=%0d outside 2..2**WIDTH", MOD);
        end
    endgenerate

    // Largest legal count; with MOD == 2**WIDTH this is all ones.
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;

    always_comb begin
        cnt_d = cnt_q;
        brw_d = 1'b0;
        if (LOAD) begin
            // Out-of-range load values clamp rather than wrap.
            cnt_d = (DIN > MAX_CNT) ? MAX_CNT : DIN;
        end else if (CNT) begin
            if (cnt_q == '0) begin
                brw_d = 1'b1;
`ifdef MOD_DOWN_COUNTER_SAT_EN
                cnt_d = '0;
`else
                cnt_d = MAX_CNT;
`endif
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            brw_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            brw_q <= brw_d;
        end
    end

    assign OUT  = cnt_q;
    assign ZERO = (cnt_q == '0);
    assign BRW  = brw_q;

endmodule

// File: tb/tb_mod_down_counter.sv
module tb_mod_down_counter;

    localparam int WIDTH = 3;
    localparam int MOD   = 6;
`ifdef MOD_DOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             CLK;
    logic             RST_N;
    logic             CNT;
    logic             LOAD;
    logic [WIDTH-1:0] DIN;
    logic [WIDTH-1:0] OUT;
    logic             ZERO;
    logic             BRW;

    mod_down_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .CNT  (CNT),
        .LOAD (LOAD),
        .DIN  (DIN),
        .OUT  (OUT),
        .ZERO (ZERO),
        .BRW  (BRW)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int    out;
        bit    brw;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: the count as a plain integer.
    int m_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, predict what the
    // following rising edge must produce, and queue it for the monitor.
    task automatic step(input bit ld, input bit cn, input int din, input string tag);
        exp_t e;
        bit   brw;
        @(negedge CLK);
        RST_N = 1'b1;
        LOAD  = ld;
        CNT   = cn;
        DIN   = WIDTH'(din);
        brw   = 1'b0;
        if (ld) begin
            m_cnt = (din < MOD) ? din : MOD - 1;
        end else if (cn) begin
            if (m_cnt == 0) begin
                brw   = 1'b1;
                m_cnt = SAT ? 0 : MOD - 1;
            end else begin
                m_cnt = (m_cnt + MOD - 1) % MOD;
            end
        end
        e.out = m_cnt;
        e.brw = brw;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: the counter presents a fresh result after every rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".out"},  int'(OUT),  e.out);
                chk({e.tag, ".zero"}, int'(ZERO), int'(e.out == 0));
                chk({e.tag, ".brw"},  int'(BRW),  int'(e.brw));
            end
        end
    end

    initial begin : stim
        // Reset held with active inputs: nothing may move.
        RST_N = 1'b0;
        LOAD  = 1'b1;
        CNT   = 1'b1;
        DIN   = 3'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_hold.out",  int'(OUT),  0);
            chk("rst_hold.zero", int'(ZERO), 1);
            chk("rst_hold.brw",  int'(BRW),  0);
        end
        m_cnt = 0;
        step(0, 0, 0, "rst_release");

        // Load 5 then count through a wrap.
        step(1, 0, 5, "load5");
        for (int i = 0; i < 7; i++) step(0, 1, 0, "countdown");

        // Clamp behaviour.
        step(1, 0, 7, "clamp7");
        step(1, 0, 6, "clamp6");
        step(1, 0, 0, "load0");

        // Priority: LOAD beats CNT, including at zero.
        step(1, 0, 3, "pri_setup3");
        step(1, 1, 1, "pri_load_over_cnt");
        step(1, 0, 0, "pri_setup0");
        step(1, 1, 4, "pri_load_at_zero");

        // Hold.
        step(1, 0, 2, "hold_setup");
        for (int i = 0; i < 4; i++) step(0, 0, 0, "hold");
        step(0, 1, 0, "hold_then_cnt");

        // Underflow from one (wrap or saturate depending on build).
        step(1, 0, 1, "uf_setup");
        for (int i = 0; i < 3; i++) step(0, 1, 0, "underflow");
        step(1, 0, 3, "uf_reload");

        // Asynchronous reset mid-cycle while OUT=4.
        step(1, 0, 4, "arst_setup");
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        chk("arst.out",  int'(OUT),  0);
        chk("arst.zero", int'(ZERO), 1);
        chk("arst.brw",  int'(BRW),  0);
        m_cnt = 0;
        step(0, 1, 0, "arst_release_cnt");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, (1 << WIDTH) - 1)), "rand");
        end

        // Let the monitor drain, bounded.
        begin
            int budget;
            budget = 8;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge CLK);
                budget--;
            end
            #3;
            chk("drain.pending", exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
